// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and types for the instruction-fetch stage.
//   DATA_W        - instruction/address width
//   NOP_INSTR     - bubble instruction, ADD(R31,R31,R31)
//   fetch_state_t - fetch FSM states
package if_fetch_pkg;

    localparam int          DATA_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h83FF_F800;

    // FETCH: request on the bus; WAIT: granted, awaiting response;
    // HOLD: response parked while decode stalls; DROP: response to be discarded.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ifid_reg.sv
// if_fetch_ifid_reg: IF/ID pipeline register; priority reset > flush > stall > load > bubble.
//   i_clk, i_reset     - clock, synchronous active-high reset
//   i_flush            - kill contents (NOP, invalid), overrides stall
//   i_stall            - decode busy, hold contents
//   i_load             - capture i_instr/i_pc4 as a valid instruction
//   i_instr, i_pc4     - incoming instruction and its pc+4
//   o_id, o_id_pc_plus4, o_id_valid - register contents
module if_fetch_ifid_reg
    import if_fetch_pkg::*;
#(
    parameter int                 W   = DATA_W,
    parameter logic [W-1:0]       NOP = NOP_INSTR
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic         i_stall,
    input  logic         i_load,
    input  logic [W-1:0] i_instr,
    input  logic [W-1:0] i_pc4,
    output logic [W-1:0] o_id,
    output logic [W-1:0] o_id_pc_plus4,
    output logic         o_id_valid
);

    logic [W-1:0] r_id;
    logic [W-1:0] r_pc4;
    logic         r_valid;

    // A bubble (no load, no stall) inserts NOP but keeps the last pc+4.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_id    <= NOP;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_id    <= NOP;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_id    <= i_load ? i_instr : NOP;
            r_pc4   <= i_load ? i_pc4 : r_pc4;
            r_valid <= i_load;
        end
    end

    assign o_id          = r_id;
    assign o_id_pc_plus4 = r_pc4;
    assign o_id_valid    = r_valid;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage between the PC and decode, one outstanding imem request.
//   i_clk, i_reset            - clock, synchronous active-high reset
//   i_ia, i_ia_plus4          - current PC and PC+4 from the PC stage
//   i_flush                   - redirect; kill in-flight fetch and IF/ID contents
//   i_id_stall                - decode cannot accept; IF/ID holds
//   o_imem_req, o_imem_addr   - fetch request and address
//   i_imem_gnt                - request accepted
//   i_imem_rvalid, i_imem_rdata - response
//   o_id, o_id_pc_plus4, o_id_valid - IF/ID register
//   o_pc_stall                - low only when the PC may advance
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                 W   = DATA_W,
    parameter logic [W-1:0]       NOP = NOP_INSTR
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_ia,
    input  logic [W-1:0] i_ia_plus4,
    input  logic         i_flush,
    input  logic         i_id_stall,
    output logic         o_imem_req,
    output logic [W-1:0] o_imem_addr,
    input  logic         i_imem_gnt,
    input  logic         i_imem_rvalid,
    input  logic [W-1:0] i_imem_rdata,
    output logic [W-1:0] o_id,
    output logic [W-1:0] o_id_pc_plus4,
    output logic         o_id_valid,
    output logic         o_pc_stall
);

    fetch_state_t r_state;
    fetch_state_t w_next;
    logic [W-1:0] r_req_pc4;
    logic [W-1:0] r_hold_instr;
    logic [W-1:0] r_hold_pc4;
    logic         w_req;
    logic         w_req_acc;
    logic         w_hold_we;
    logic         w_load_ifid;
    logic         w_from_hold;
    logic [W-1:0] w_ld_instr;
    logic [W-1:0] w_ld_pc4;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= FETCH;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: w_next = !i_imem_gnt ? FETCH : (i_flush ? DROP : WAIT);
            WAIT:  w_next = i_imem_rvalid ? ((i_flush || !i_id_stall) ? FETCH : HOLD)
                                          : (i_flush ? DROP : WAIT);
            HOLD:  w_next = (i_flush || !i_id_stall) ? FETCH : HOLD;
            DROP:  w_next = i_imem_rvalid ? FETCH : DROP;
            default: w_next = FETCH;
        endcase
    end

    // Reset gates every strobe so nothing launches or loads in the reset cycle.
    always_comb begin
        w_req       = !i_reset && r_state == FETCH;
        w_req_acc   = w_req && i_imem_gnt && !i_flush;
        w_hold_we   = !i_reset && r_state == WAIT && i_imem_rvalid && !i_flush && i_id_stall;
        w_from_hold = r_state == HOLD;
        w_load_ifid = !i_reset && !i_flush && !i_id_stall &&
                      ((r_state == WAIT && i_imem_rvalid) || w_from_hold);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_req_pc4    <= '0;
            r_hold_instr <= NOP;
            r_hold_pc4   <= '0;
        end else begin
            if (w_req_acc) r_req_pc4 <= i_ia_plus4;
            if (w_hold_we) begin
                r_hold_instr <= i_imem_rdata;
                r_hold_pc4   <= r_req_pc4;
            end
        end
    end

    assign w_ld_instr = w_from_hold ? r_hold_instr : i_imem_rdata;
    assign w_ld_pc4   = w_from_hold ? r_hold_pc4 : r_req_pc4;

    if_fetch_ifid_reg #(.W(W), .NOP(NOP)) u_ifid (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_flush       (i_flush),
        .i_stall       (i_id_stall),
        .i_load        (w_load_ifid),
        .i_instr       (w_ld_instr),
        .i_pc4         (w_ld_pc4),
        .o_id          (o_id),
        .o_id_pc_plus4 (o_id_pc_plus4),
        .o_id_valid    (o_id_valid)
    );

    assign o_imem_req  = w_req;
    assign o_imem_addr = i_ia;
    // PC advances once per instruction handed to decode, or to take a redirect.
    assign o_pc_stall  = !w_load_ifid && !i_flush;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scoreboard bench for if_fetch; responses pushed on rvalid, popped when IF/ID loads.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h83FF_F800;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ia, ia_plus4, imem_addr, imem_rdata, id, id_pc_plus4;
    logic        flush, id_stall, imem_req, imem_gnt, imem_rvalid, id_valid, pc_stall;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    if_fetch dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_ia          (ia),
        .i_ia_plus4    (ia_plus4),
        .i_flush       (flush),
        .i_id_stall    (id_stall),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_id          (id),
        .o_id_pc_plus4 (id_pc_plus4),
        .o_id_valid    (id_valid),
        .o_pc_stall    (pc_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_pc(input logic [31:0] a);
        ia       = a;
        ia_plus4 = a + 32'd4;
    endtask

    task automatic resp(input logic [31:0] d, input logic [31:0] pc4, input bit keep);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        if (keep) sb.push_back({d, pc4});
    endtask

    // Scoreboard monitor: a valid IF/ID after an edge where decode was not stalled is a fresh load.
    always begin
        logic       s;
        logic [63:0] e;
        @(posedge clk);
        s = id_stall;
        #1;
        if (id_valid && !s) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", id, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("sb_id", id, e[63:32]);
                chk("sb_pc4", id_pc_plus4, e[31:0]);
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; id_stall = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; set_pc(32'h8000_0000);
        @(posedge clk); @(negedge clk); #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_id", id, NOP);
        chk("rst_pc4", id_pc_plus4, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        @(negedge clk); reset = 1'b0; imem_gnt = 1'b1; #1;
        chk("t1_req", {31'b0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h8000_0000);
        chk("t1_stall_fetch", {31'b0, pc_stall}, 32'd1);
        @(negedge clk); imem_gnt = 1'b0; resp(32'h1234_5678, 32'h8000_0004, 1); #1;
        chk("t1_stall_rvalid", {31'b0, pc_stall}, 32'd0);
        chk("t1_req_wait", {31'b0, imem_req}, 32'd0);
        @(negedge clk); imem_rvalid = 1'b0; set_pc(32'h8000_0004); #1;
        chk("t1_id", id, 32'h1234_5678);
        chk("t1_idpc4", id_pc_plus4, 32'h8000_0004);
        chk("t1_valid", {31'b0, id_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("t2_req", {31'b0, imem_req}, 32'd1);
            chk("t2_addr", imem_addr, 32'h8000_0004);
            chk("t2_stall", {31'b0, pc_stall}, 32'd1);
            if (i > 0) chk("t2_valid", {31'b0, id_valid}, 32'd0);
        end
        @(negedge clk); imem_gnt = 1'b1;
        @(negedge clk); imem_gnt = 1'b0; id_stall = 1'b1; resp(32'hAAAA_0001, 32'h8000_0008, 1); #1;
        chk("t3_stall_rv", {31'b0, pc_stall}, 32'd1);
        @(negedge clk); imem_rvalid = 1'b0; #1;
        chk("t3_stall_hold", {31'b0, pc_stall}, 32'd1);
        chk("t3_req_hold", {31'b0, imem_req}, 32'd0);
        chk("t3_id_hold", id, NOP);
        @(negedge clk); id_stall = 1'b0; #1;
        chk("t3_stall_rel", {31'b0, pc_stall}, 32'd0);
        @(negedge clk); set_pc(32'h8000_0008); imem_gnt = 1'b1; #1;
        chk("t3_id", id, 32'hAAAA_0001);
        chk("t4_addr", imem_addr, 32'h8000_0008);
        @(negedge clk); imem_gnt = 1'b0; flush = 1'b1; #1;
        chk("t4_stall_flush", {31'b0, pc_stall}, 32'd0);
        @(negedge clk); flush = 1'b0; set_pc(32'h0000_1000); #1;
        chk("t4_req_drop", {31'b0, imem_req}, 32'd0);
        @(negedge clk); resp(32'hDEAD_BEEF, 32'h0, 0); #1;
        chk("t4_stall_drop", {31'b0, pc_stall}, 32'd1);
        @(negedge clk); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
        chk("t4_req", {31'b0, imem_req}, 32'd1);
        chk("t4_addr_new", imem_addr, 32'h0000_1000);
        chk("t4_id", id, NOP);
        chk("t4_valid", {31'b0, id_valid}, 32'd0);
        @(negedge clk); imem_gnt = 1'b0; resp(32'h1111_2222, 32'h0000_1004, 1);
        @(negedge clk); imem_rvalid = 1'b0; id_stall = 1'b1; set_pc(32'h0000_1004); #1;
        chk("t5_valid_pre", {31'b0, id_valid}, 32'd1);
        @(negedge clk); flush = 1'b1; #1;
        chk("t5_valid_stall", {31'b0, id_valid}, 32'd1);
        @(negedge clk); flush = 1'b0; id_stall = 1'b0; set_pc(32'h0000_2000); #1;
        chk("t5_id", id, NOP);
        chk("t5_valid", {31'b0, id_valid}, 32'd0);
        imem_gnt = 1'b1;
        @(negedge clk); imem_gnt = 1'b0; reset = 1'b1; set_pc(32'h8000_0000);
        resp(32'h5555_5555, 32'h0, 0); #1;
        chk("t6_req_rst", {31'b0, imem_req}, 32'd0);
        @(negedge clk); reset = 1'b0; #1;
        chk("t6_req", {31'b0, imem_req}, 32'd1);
        chk("t6_addr", imem_addr, 32'h8000_0000);
        chk("t6_stall", {31'b0, pc_stall}, 32'd1);
        @(negedge clk); imem_rvalid = 1'b0; #1;
        chk("t6_valid", {31'b0, id_valid}, 32'd0);
        set_pc(32'hFFFF_FFFC); imem_gnt = 1'b1; #1;
        chk("t7_pc4_in", ia_plus4, 32'd0);
        @(negedge clk); imem_gnt = 1'b0; #1;
        chk("t7_stall_wait", {31'b0, pc_stall}, 32'd1);
        @(negedge clk); resp(32'h0BAD_F00D, 32'h0000_0000, 1);
        @(negedge clk); imem_rvalid = 1'b0; #1;
        chk("t7_id", id, 32'h0BAD_F00D);
        chk("t7_idpc4", id_pc_plus4, 32'h0000_0000);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
